// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned value commit
// and optional leading-zero blanking. Includes the nibble-to-segment decoder.

module seven_segment (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);
  // Active-low segments ordered {a,b,c,d,e,f,g}
  always_comb begin
    seg_c = 7'h7F;
    unique case (nibble)
      4'h0: seg_c = 7'h01;
      4'h1: seg_c = 7'h4F;
      4'h2: seg_c = 7'h12;
      4'h3: seg_c = 7'h06;
      4'h4: seg_c = 7'h4C;
      4'h5: seg_c = 7'h24;
      4'h6: seg_c = 7'h20;
      4'h7: seg_c = 7'h0F;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h04;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h60;
      4'hC: seg_c = 7'h31;
      4'hD: seg_c = 7'h42;
      4'hE: seg_c = 7'h30;
      4'hF: seg_c = 7'h38;
      default: seg_c = 7'h7F;
    endcase
  end
endmodule

module seven_segment_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);
  localparam int unsigned VAL_W     = 4 * NUM_DIGITS;
  localparam int unsigned ON_CYCLES = REFRESH_DIV - BLANK_CYCLES;
  localparam int unsigned CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [VAL_W-1:0]      pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic                  first_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_q, frame_start_d;
  logic                  wrap_c;
  logic [VAL_W-1:0]      upper_c;
  logic [6:0]            dec_seg_c;
  logic                  suppress_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_BLANK;
      cnt_q           <= '0;
      digit_q         <= '0;
      disp_q          <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      first_q         <= 1'b1;
      an_q            <= '1;
      seg_q           <= 7'h7F;
      dp_q            <= 1'b1;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      digit_q         <= digit_d;
      disp_q          <= disp_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      first_q         <= 1'b0;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      frame_start_q   <= frame_start_d;
    end
  end

  // Slot sequencing: BLANK then ON per digit, wrap after the last digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    wrap_c  = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
            digit_d = '0;
            wrap_c  = 1'b1;
          end else begin
            digit_d = digit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Pending capture; a load on the wrap cycle bypasses straight into the display
  always_comb begin
    pending_d       = load ? value : pending_q;
    pending_valid_d = pending_valid_q | load;
    disp_d          = disp_q;
    if (wrap_c) begin
      disp_d          = (load || pending_valid_q) ? pending_d : disp_q;
      pending_valid_d = 1'b0;
    end
  end

  assign upper_c    = disp_q >> {digit_q, 2'b00};
  assign suppress_c = lz_en && (digit_q != '0) && (upper_c == '0);

  seven_segment u_dec (
    .nibble (upper_c[3:0]),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    an_d          = '1;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    frame_start_d = (state_q == ST_BLANK) && (digit_q == '0) && (cnt_q == '0) && !first_q;
    if (state_q == ST_ON && !suppress_c) begin
      an_d  = ~(NUM_DIGITS'(1) << digit_q);
      seg_d = dec_seg_c;
      dp_d  = ~dp_mask[digit_q];
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized and directed bench for seven_segment_scanner, compared cycle by cycle
// against a timeline model derived from elapsed cycles since reset release.

module tb_seven_segment_scanner;
  localparam int unsigned N = 4;
  localparam int unsigned R = 8;
  localparam int unsigned B = 2;
  localparam int unsigned FRAME = N * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic          lz_en;
  logic [3:0]    dp_mask;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  int unsigned s;
  logic [15:0] m_disp;
  logic [15:0] m_pend;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .load        (load),
    .lz_en       (lz_en),
    .dp_mask     (dp_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t s=%0d got=%h exp=%h", tag, $time, s, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    return tbl[n];
  endfunction

  // One clock: predict registered outputs from the timeline position, then advance
  task automatic cycle();
    int unsigned pos, dig;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs, supp;
    @(posedge clk);
    pos   = s % R;
    dig   = (s / R) % N;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fs  = (s > 0) && (pos == 0) && (dig == 0);
    supp  = lz_en && (dig > 0) && ((m_disp >> (4 * dig)) == 16'h0);
    if (pos >= B && !supp) begin
      e_an      = 4'hF;
      e_an[dig] = 1'b0;
      e_seg     = hex7(4'((m_disp >> (4 * dig)) & 16'hF));
      e_dp      = ~dp_mask[dig];
    end
    if (load) m_pend = value;
    if ((s + 1) % FRAME == 0) m_disp = m_pend;
    s++;
    @(negedge clk);
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the next edge would leave the model at frame offset 'target'
  task automatic run_to(input int unsigned target);
    for (int i = 0; i < 2 * FRAME && (s % FRAME) != target; i++) cycle();
    check_eq("run_to_reached", 32'(s % FRAME), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  task automatic model_reset();
    s      = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
  endtask

  initial begin
    logic [15:0] masks [5];
    masks   = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    rst_n   = 1'b0;
    value   = 16'h0;
    load    = 1'b0;
    lz_en   = 1'b0;
    dp_mask = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Release and first frame: blank until the first ON, then digit rotation
    run(2);
    check_eq("pre_on_an", 32'(an), 32'hF);
    run(1);
    check_eq("first_on_an", 32'(an), 32'hE);
    run(40);

    // Mid-frame load appears only from the next frame
    run_to(5);
    value = 16'h1234; load = 1'b1;
    cycle();
    run(FRAME + 10);

    // Two loads in one frame: last write wins
    run_to(3);
    value = 16'hAAAA; load = 1'b1;
    cycle();
    run(4);
    value = 16'h0001; load = 1'b1;
    cycle();
    run(FRAME + 5);

    // Leading-zero blanking on 0001
    lz_en = 1'b1;
    run(2 * FRAME);

    // Load exactly on the wrap edge commits immediately
    run_to(FRAME - 1);
    value = 16'h9C0E; load = 1'b1;
    cycle();
    check_eq("pv_after_wrap", 32'(dut.pending_valid_q), 32'h0);
    run(FRAME);

    // Reset during digit 2 ON with a pending load discards it
    run_to(2 * R + B + 1);
    value = 16'h5678; load = 1'b1;
    cycle();
    run(1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    load = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    lz_en = 1'b0;
    run(FRAME + 12);

    // Randomized traffic
    for (int i = 0; i < 1400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        value = 16'($urandom) & masks[$urandom_range(0, 4)];
        load  = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
